// File: rtl/vga_scene_ctrl.sv
// Frame-synchronous scene sequencer: TITLE / PLAY / OVER (/ PAUSE).
// Optional PLAY<->PAUSE toggle is built only when SCENE_PAUSE_EN is defined.
module vga_scene_ctrl #(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned OVER_FRAMES  = 180
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        game_over,
    output logic [1:0]  scene,
    output logic        scene_chg,
    output logic        blink,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2,
        S_PAUSE = 2'd3
    } scene_e;

    localparam logic [15:0] OVER_LOAD  = 16'(OVER_FRAMES - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    scene_e      state_q;
    scene_e      state_d;
    logic [15:0] over_cnt_q;
    logic [15:0] over_cnt_d;
    logic [7:0]  blink_cnt_q;
    logic        blink_q;
    logic        chg;

    logic start_q;
    logic start_rise;
    logic pause_rise;
    logic pend_start;
    logic pend_over;
    logic pend_pause;

    assign start_rise = start_btn & ~start_q;

    // Edge detectors reset high so a button held through reset is not an event
    always_ff @(posedge clk) begin
        if (clr) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_btn;
        end
    end

`ifdef SCENE_PAUSE_EN
    logic pause_q;

    assign pause_rise = pause_btn & ~pause_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            pause_q <= 1'b1;
        end else begin
            pause_q <= pause_btn;
        end
    end
`else
    logic unused_pause;

    assign unused_pause = pause_btn;
    assign pause_rise   = 1'b0;
`endif

    // Pending flags: accumulate within a frame, reload with the tick-cycle event
    always_ff @(posedge clk) begin
        if (clr) begin
            pend_start <= 1'b0;
            pend_over  <= 1'b0;
            pend_pause <= 1'b0;
        end else if (frame_tick) begin
            pend_start <= start_rise;
            pend_over  <= game_over;
            pend_pause <= pause_rise;
        end else begin
            pend_start <= pend_start | start_rise;
            pend_over  <= pend_over | game_over;
            pend_pause <= pend_pause | pause_rise;
        end
    end

    always_comb begin
        state_d    = state_q;
        over_cnt_d = over_cnt_q;
        if (frame_tick) begin
            unique case (state_q)
                S_TITLE: begin
                    if (pend_start) begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (pend_over) begin
                        state_d    = S_OVER;
                        over_cnt_d = OVER_LOAD;
                    end else if (pend_pause) begin
                        state_d = S_PAUSE;
                    end
                end
                S_OVER: begin
                    if (pend_start || over_cnt_q == 16'd0) begin
                        state_d = S_TITLE;
                    end else begin
                        over_cnt_d = over_cnt_q - 16'd1;
                    end
                end
                S_PAUSE: begin
`ifdef SCENE_PAUSE_EN
                    if (pend_over) begin
                        state_d    = S_OVER;
                        over_cnt_d = OVER_LOAD;
                    end else if (pend_pause) begin
                        state_d = S_PLAY;
                    end
`else
                    state_d = S_TITLE;
`endif
                end
                default: state_d = S_TITLE;
            endcase
        end
    end

    assign chg = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_TITLE;
            over_cnt_q  <= 16'd0;
            scene_chg   <= 1'b0;
            frame_cnt   <= 16'd0;
            blink_cnt_q <= 8'd0;
            blink_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            over_cnt_q <= over_cnt_d;
            scene_chg  <= chg;
            if (chg) begin
                frame_cnt   <= 16'd0;
                blink_cnt_q <= 8'd0;
                blink_q     <= 1'b1;
            end else if (frame_tick) begin
                if (frame_cnt != 16'hFFFF) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= 8'd0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end
        end
    end

    assign scene = state_q;
    assign blink = blink_q | (state_q == S_PLAY);

endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Directed bench for vga_scene_ctrl (BLINK_FRAMES=4, OVER_FRAMES=3).
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_vga_scene_ctrl;

    logic        clk;
    logic        clr;
    logic        frame_tick;
    logic        start_btn;
    logic        pause_btn;
    logic        game_over;
    logic [1:0]  scene;
    logic        scene_chg;
    logic        blink;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    vga_scene_ctrl #(
        .BLINK_FRAMES(4),
        .OVER_FRAMES (3)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .frame_tick(frame_tick),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .game_over (game_over),
        .scene     (scene),
        .scene_chg (scene_chg),
        .blink     (blink),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr        = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b1;
        pause_btn  = 1'b0;
        game_over  = 1'b0;
        step();
        step();
        chk("rst_scene", 32'(scene), 32'd0);
        chk("rst_chg", 32'(scene_chg), 32'd0);
        chk("rst_blink", 32'(blink), 32'd1);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);

        // 1: button held through reset is not a start
        clr = 1'b0;
        step();
        start_btn = 1'b0;
        step();
        tick();
        step();
        tick();
        chk("t1_scene", 32'(scene), 32'd0);
        chk("t1_blink", 32'(blink), 32'd1);
        chk("t1_fcnt", 32'(frame_cnt), 32'd2);

        // 2: start mid-frame
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
        step();
        chk("t2_hold", 32'(scene), 32'd0);
        tick();
        chk("t2_scene", 32'(scene), 32'd1);
        chk("t2_chg", 32'(scene_chg), 32'd1);
        chk("t2_fcnt", 32'(frame_cnt), 32'd0);
        chk("t2_blink", 32'(blink), 32'd1);
        step();
        chk("t2_chg_off", 32'(scene_chg), 32'd0);

        // 3: game_over coincident with tick is deferred a frame
        game_over  = 1'b1;
        frame_tick = 1'b1;
        step();
        game_over  = 1'b0;
        frame_tick = 1'b0;
        chk("t3_defer", 32'(scene), 32'd1);
        chk("t3_fcnt", 32'(frame_cnt), 32'd1);
        step();
        step();
        tick();
        chk("t3_over", 32'(scene), 32'd2);
        chk("t3_chg", 32'(scene_chg), 32'd1);
        chk("t3_fcnt0", 32'(frame_cnt), 32'd0);

        // 4: OVER auto-return after OVER_FRAMES ticks
        step();
        tick();
        chk("t4_s1", 32'(scene), 32'd2);
        chk("t4_f1", 32'(frame_cnt), 32'd1);
        step();
        tick();
        chk("t4_s2", 32'(scene), 32'd2);
        chk("t4_f2", 32'(frame_cnt), 32'd2);
        chk("t4_chg_quiet", 32'(scene_chg), 32'd0);
        step();
        tick();
        chk("t4_s3", 32'(scene), 32'd0);
        chk("t4_f3", 32'(frame_cnt), 32'd0);
        chk("t4_chg", 32'(scene_chg), 32'd1);

        // 5: blink half-period of 4 ticks in TITLE
        for (int i = 1; i <= 8; i++) begin
            step();
            tick();
            chk($sformatf("t5_blink%0d", i), 32'(blink),
                (i < 4) ? 32'd1 : (i < 8) ? 32'd0 : 32'd1);
            chk($sformatf("t5_fcnt%0d", i), 32'(frame_cnt), 32'(i));
        end

        // 6: pause toggle, then pause + game_over in one frame
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        tick();
        chk("t6_play", 32'(scene), 32'd1);
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        step();
        tick();
`ifdef SCENE_PAUSE_EN
        chk("t6_pause", 32'(scene), 32'd3);
        chk("t6_pchg", 32'(scene_chg), 32'd1);
`else
        chk("t6_nopause", 32'(scene), 32'd1);
        chk("t6_nochg", 32'(scene_chg), 32'd0);
`endif
        pause_btn = 1'b1;
        step();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        pause_btn = 1'b0;
        step();
        tick();
        chk("t6_over", 32'(scene), 32'd2);
        chk("t6_ochg", 32'(scene_chg), 32'd1);

        // clr beats a coincident tick and clears pending start
        step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        clr        = 1'b1;
        frame_tick = 1'b1;
        step();
        clr        = 1'b0;
        frame_tick = 1'b0;
        chk("clr_scene", 32'(scene), 32'd0);
        chk("clr_chg", 32'(scene_chg), 32'd0);
        step();
        tick();
        chk("clr_pend", 32'(scene), 32'd0);
        chk("clr_fcnt", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scene_ctrl.md
# vga_scene_ctrl

Frame-synchronous scene sequencer for the VGA game display. Converts asynchronous-in-time game events (start button, game-over pulse, optional pause) into a scene select that changes only at the start of vertical blank, so the pixel generator never tears mid-frame. Also supplies a text-blink enable and a per-scene frame counter. Sits between the game logic and the VGA pixel/timing path.

## Interface
- BLINK_FRAMES, 30: frames per blink half-period; legal range 1..255.
- OVER_FRAMES, 180: frames the OVER scene is held before auto-return to TITLE; legal range 1..65535.
- clk  in  1  pixel clock; the block's only clock.
- clr  in  1  reset; synchronous and active-high.
- frame_tick  in  1  one-cycle pulse at start of vertical blank, from the timing generator.
- start_btn  in  1  debounced level; a rising edge is a start request.
- pause_btn  in  1  debounced level; a rising edge is a pause toggle. Used only with SCENE_PAUSE_EN.
- game_over  in  1  one-cycle pulse from game logic.
- scene  out  2  0 = TITLE, 1 = PLAY, 2 = OVER, 3 = PAUSE.
- scene_chg  out  1  one-cycle pulse; high in the first cycle `scene` holds a new value.
- blink  out  1  text-visible enable.
- frame_cnt  out  16  frame_ticks since entering the current scene; saturates at 0xFFFF.

## Operation
- Edge detect: start_q and pause_q register the button levels. A rise is `btn & ~btn_q`.
  - start_q and pause_q reset to 1, so a button held through reset produces no event.
- Pending flags: pend_start, pend_pause and pend_over.
  - Each flag sets on its event and holds until the next frame_tick.
  - On a frame_tick cycle, each flag is loaded with that cycle's event value. An event coincident with frame_tick is therefore deferred one frame.
  - All flags are consumed or discarded at every tick. Events irrelevant to the current state are dropped.
- State transitions are evaluated only on frame_tick cycles, using the pending flags:
  - TITLE: pend_start -> PLAY.
  - PLAY: pend_over -> OVER; else pend_pause -> PAUSE (macro only); pend_start ignored.
  - OVER: pend_start -> TITLE; else over_cnt == 0 -> TITLE; else over_cnt decrements.
  - PAUSE: pend_over -> OVER; else pend_pause -> PLAY.
- Entering OVER loads over_cnt = OVER_FRAMES-1. OVER therefore lasts exactly OVER_FRAMES ticks absent a start.
- On a scene change (same edge):
  - scene_chg = 1.
  - frame_cnt = 0.
  - blink_cnt = 0.
  - blink = 1.
- On a tick with no change:
  - frame_cnt increments, saturating at 0xFFFF.
  - blink_cnt increments; when it reaches BLINK_FRAMES-1 it wraps to 0 and blink toggles.
- blink is forced to 1 while scene == PLAY.

## Timing
- Reset values: scene = 0, scene_chg = 0, blink = 1, frame_cnt = 0, all pending flags = 0, over_cnt = 0, blink_cnt = 0.
- Latency from event to scene change:
  - At the first frame_tick strictly after the event cycle.
  - scene is visible one clk after that tick edge.
- scene_chg is never high for two consecutive cycles.
- No handshake on inputs: events are fire-and-forget and are never lost before the next tick. Multiple events of one type within one frame collapse to one.
- clr overrides everything, including a coincident frame_tick or event. The next scene change is possible only at a frame_tick after clr deasserts.
- Between ticks, only the edge detectors and pending flags change.

## Configuration
- SCENE_PAUSE_EN defined:
  - pause_btn rises toggle PLAY <-> PAUSE.
  - In PAUSE, frame_cnt and blink still advance per tick.
- SCENE_PAUSE_EN undefined:
  - pause_btn is ignored (port kept, pend_pause tied 0).
  - scene never equals 3; PAUSE logic is not synthesized.

## Test plan
Bench parameters: BLINK_FRAMES = 4, OVER_FRAMES = 3.

1. Reset with start_btn held high, release, then tick ×2 -> scene stays 0; blink = 1.
2. start_btn rise mid-frame, then tick -> scene = 1 one cycle after the tick, with scene_chg = 1 for exactly one cycle and frame_cnt = 0.
3. game_over pulse in the same cycle as a tick while in PLAY -> scene stays 1 after that tick; becomes 2 after the next tick.
4. In OVER, with no start, tick ×3 -> scene = 2 after ticks 1 and 2; scene = 0 after the 3rd tick. frame_cnt reads 0, 1, 2, then 0.
5. In TITLE, tick ×8 -> blink toggles after ticks 4 and 8 (1 -> 0 -> 1).
6. With SCENE_PAUSE_EN: in PLAY, pause rise + tick -> scene = 3. Then pause and game_over in the same frame + tick -> scene = 2.
   - Without SCENE_PAUSE_EN: the same stimulus keeps scene = 1 until the game_over takes effect.
